proc_csr_io: RTL and testbench

- Parametrised CSR I/O unit for the TinyRV1 pipelined processor; replaces the fixed in0..in2 / out0..out2 CSR wiring with NUM_IN input and NUM_OUT output channels.
- The processor's D stage reads through the csrr port; its W stage writes through the csrw port.
- Each output channel provides a level register and a buffered valid/ready stream, so an external consumer sees every write.
- Also provides a free-running cycle counter CSR and a status CSR; back-pressure on writes is returned to the processor as a stall.

---
 rtl/proc_csr_io_pkg.sv | 18 +
 rtl/proc_csr_fifo.sv | 60 ++++++
 rtl/proc_csr_io.sv | 119 +++++++++++
 tb/tb_proc_csr_io.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_csr_io_pkg.sv
// Shared constants and types for the TinyRV1 CSR I/O unit: fixed CSR addresses,
// default channel bases and the bit layout of the status CSR.
package proc_csr_io_pkg;

    localparam int DATA_W = 32;

    typedef logic [11:0] csr_addr_t;

    localparam csr_addr_t CSR_CYCLE    = 12'hFC0;
    localparam csr_addr_t CSR_STATUS   = 12'hFC1;
    localparam csr_addr_t DEF_IN_BASE  = 12'hFC2;
    localparam csr_addr_t DEF_OUT_BASE = 12'h7C2;

    // Status CSR: FIFO j full at bit j, FIFO j nonempty at bit 8+j
    localparam int STATUS_FULL_OFS   = 0;
    localparam int STATUS_NEMPTY_OFS = 8;

endpackage

// File: rtl/proc_csr_fifo.sv
// 32-bit synchronous FIFO backing one output stream; full/empty come straight
// from the registered count so they never depend on this cycle's dequeue.
module proc_csr_fifo
    import proc_csr_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enq_val_i,
    input  logic [DATA_W-1:0] enq_data_i,
    input  logic              deq_rdy_i,
    output logic              deq_val_o,
    output logic [DATA_W-1:0] deq_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              enq, deq;

    assign full_o     = (cnt_q == CNT_W'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign deq_val_o  = ~empty_o;
    assign deq_data_o = mem_q[rdPtr_q];
    assign enq        = enq_val_i & ~full_o;
    assign deq        = deq_rdy_i & ~empty_o;

    // Pointers wrap for free because DEPTH is a power of two
    always_comb begin
        wrPtr_d = wrPtr_q + PTR_W'(enq);
        rdPtr_d = rdPtr_q + PTR_W'(deq);
        cnt_d   = cnt_q + CNT_W'(enq) - CNT_W'(deq);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            cnt_q   <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wrPtr_q] <= enq_data_i;
        end
    end

endmodule

// File: rtl/proc_csr_io.sv
// Parametrised CSR I/O unit: sampled input channels, level + streamed output
// channels, cycle counter and status CSR, with write back-pressure as a stall.
module proc_csr_io
    import proc_csr_io_pkg::*;
#(
    parameter int        NUM_IN     = 3,
    parameter int        NUM_OUT    = 3,
    parameter int        FIFO_DEPTH = 4,
    parameter csr_addr_t IN_BASE    = DEF_IN_BASE,
    parameter csr_addr_t OUT_BASE   = DEF_OUT_BASE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*32-1:0]    in_data,
    input  logic                    csrr_val,
    input  logic [11:0]             csrr_addr,
    output logic [31:0]             csrr_rdata,
    input  logic                    csrw_val,
    output logic                    csrw_rdy,
    input  logic [11:0]             csrw_addr,
    input  logic [31:0]             csrw_wdata,
    output logic                    csr_illegal,
    output logic [NUM_OUT*32-1:0]   out_data,
    output logic [NUM_OUT-1:0]      outq_val,
    input  logic [NUM_OUT-1:0]      outq_rdy,
    output logic [NUM_OUT*32-1:0]   outq_data
);

    logic [NUM_IN-1:0][31:0]  inSmp_q;
    logic [NUM_OUT-1:0][31:0] outData_q, outData_d;
    logic [31:0]              cycle_q;

    logic [NUM_OUT-1:0] fifoFull, fifoEmpty, wrSel, enq;
    logic [31:0]        status;
    logic               wrHit, rdIllegal;
    csr_addr_t          rdOfs, wrOfs;

    // Offsets wrap modulo 2^12, so addresses below the base land far out of range
    assign rdOfs = csrr_addr - IN_BASE;
    assign wrOfs = csrw_addr - OUT_BASE;

    always_comb begin
        wrSel = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            wrSel[j] = (wrOfs == csr_addr_t'(j));
        end
    end

    assign wrHit    = |wrSel;
    assign csrw_rdy = ~|(wrSel & fifoFull);
    assign enq      = {NUM_OUT{csrw_val}} & wrSel & ~fifoFull;

    always_comb begin
        outData_d = outData_q;
        for (int j = 0; j < NUM_OUT; j++) begin
            if (enq[j]) begin
                outData_d[j] = csrw_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inSmp_q   <= '0;
            outData_q <= '0;
            cycle_q   <= '0;
        end else begin
            inSmp_q   <= in_data;
            outData_q <= outData_d;
            cycle_q   <= cycle_q + 32'd1;
        end
    end

    always_comb begin
        status = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            status[STATUS_FULL_OFS + j]   = fifoFull[j];
            status[STATUS_NEMPTY_OFS + j] = ~fifoEmpty[j];
        end
    end

    always_comb begin
        csrr_rdata = '0;
        rdIllegal  = 1'b0;
        if (csrr_addr == CSR_CYCLE) begin
            csrr_rdata = cycle_q;
        end else if (csrr_addr == CSR_STATUS) begin
            csrr_rdata = status;
        end else if (rdOfs < csr_addr_t'(NUM_IN)) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (rdOfs == csr_addr_t'(i)) begin
                    csrr_rdata = inSmp_q[i];
                end
            end
        end else begin
            rdIllegal = 1'b1;
        end
    end

    assign csr_illegal = (csrr_val & rdIllegal) | (csrw_val & ~wrHit);
    assign out_data    = outData_q;

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_outq
        proc_csr_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i      (clk),
            .rst_ni     (rst),
            .enq_val_i  (enq[j]),
            .enq_data_i (csrw_wdata),
            .deq_rdy_i  (outq_rdy[j]),
            .deq_val_o  (outq_val[j]),
            .deq_data_o (outq_data[j*32 +: 32]),
            .full_o     (fifoFull[j]),
            .empty_o    (fifoEmpty[j])
        );
    end

endmodule

// File: tb/tb_proc_csr_io.sv
// Scoreboard bench for proc_csr_io: stimulus pushes expected CSR responses and
// stream words into queues, a negedge monitor pops and compares them.
module tb_proc_csr_io;

    logic         clk = 1'b0;
    logic         rst;
    logic [95:0]  in_data;
    logic         csrr_val;
    logic [11:0]  csrr_addr;
    logic [31:0]  csrr_rdata;
    logic         csrw_val;
    logic         csrw_rdy;
    logic [11:0]  csrw_addr;
    logic [31:0]  csrw_wdata;
    logic         csr_illegal;
    logic [95:0]  out_data;
    logic [2:0]   outq_val;
    logic [2:0]   outq_rdy;
    logic [95:0]  outq_data;

    typedef struct {
        bit          rv;
        logic [31:0] rdata;
        bit          ill;
        bit          wv;
        bit          rdy;
    } cyc_t;

    cyc_t        cycQ[$];
    logic [31:0] streamQ [3][$];

    int assertCount = 0;
    int failCount   = 0;

    proc_csr_io dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .csrr_val    (csrr_val),
        .csrr_addr   (csrr_addr),
        .csrr_rdata  (csrr_rdata),
        .csrw_val    (csrw_val),
        .csrw_rdy    (csrw_rdy),
        .csrw_addr   (csrw_addr),
        .csrw_wdata  (csrw_wdata),
        .csr_illegal (csr_illegal),
        .out_data    (out_data),
        .outq_val    (outq_val),
        .outq_rdy    (outq_rdy),
        .outq_data   (outq_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Inputs change 2 time units after each rising edge; the monitor samples mid-cycle
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        csrr_val  = 1'b0;
        csrr_addr = 12'h000;
        csrw_val  = 1'b0;
        csrw_addr = 12'h000;
        csrw_wdata = 32'h0;
    endtask

    task automatic applyStimulus(input bit rv, input logic [11:0] ra, input logic [31:0] expRdata,
                                 input bit expIll, input bit wv, input logic [11:0] wa,
                                 input logic [31:0] wd, input bit expRdy);
        cyc_t e;
        csrr_val   = rv;
        csrr_addr  = ra;
        csrw_val   = wv;
        csrw_addr  = wa;
        csrw_wdata = wd;
        e.rv = rv; e.rdata = expRdata; e.ill = expIll; e.wv = wv; e.rdy = expRdy;
        if (rv || wv) cycQ.push_back(e);
        if (wv && expRdy && wa >= 12'h7C2 && wa <= 12'h7C4) streamQ[int'(wa - 12'h7C2)].push_back(wd);
        tick();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (csrr_val || csrw_val) begin
                if (cycQ.size() == 0) begin
                    failCount++;
                    assertCount++;
                    $display("[TB] FAIL cycQ: request seen with no expectation queued");
                end else begin
                    cyc_t e;
                    e = cycQ.pop_front();
                    if (e.rv) checkOutput("csrr_rdata", csrr_rdata, e.rdata);
                    checkOutput("csr_illegal", 32'(csr_illegal), 32'(e.ill));
                    if (e.wv) checkOutput("csrw_rdy", 32'(csrw_rdy), 32'(e.rdy));
                end
            end
            for (int j = 0; j < 3; j++) begin
                if (outq_val[j] && outq_rdy[j]) begin
                    if (streamQ[j].size() == 0) begin
                        failCount++;
                        assertCount++;
                        $display("[TB] FAIL stream%0d: unexpected word %h", j, outq_data[j*32 +: 32]);
                    end else begin
                        logic [31:0] expWord;
                        expWord = streamQ[j].pop_front();
                        checkOutput($sformatf("outq_data%0d", j), outq_data[j*32 +: 32], expWord);
                    end
                end
            end
        end
    end

    initial begin
        rst      = 1'b0;
        in_data  = {32'h0000_1111, 32'h0000_0000, 32'hA5A5_0000};
        outq_rdy = 3'b000;
        idle();

        #2;
        checkOutput("reset out_data0", out_data[31:0], 32'h0);
        checkOutput("reset out_data1", out_data[63:32], 32'h0);
        checkOutput("reset out_data2", out_data[95:64], 32'h0);
        checkOutput("reset outq_val", 32'(outq_val), 32'h0);
        checkOutput("reset csrw_rdy", 32'(csrw_rdy), 32'h1);
        tick();
        tick();

        rst = 1'b1;
        repeat (5) tick();
        applyStimulus(1, 12'hFC0, 32'd5, 0, 0, 12'h0, 32'h0, 1);

        // Input sampling: change and read in the same cycle sees the old value
        applyStimulus(1, 12'hFC2, 32'hA5A5_0000, 0, 0, 12'h0, 32'h0, 1);
        in_data[95:64] = 32'h0000_1234;
        applyStimulus(1, 12'hFC4, 32'h0000_1111, 0, 0, 12'h0, 32'h0, 1);
        applyStimulus(1, 12'hFC4, 32'h0000_1234, 0, 0, 12'h0, 32'h0, 1);
        applyStimulus(1, 12'hFC5, 32'h0, 1, 0, 12'h0, 32'h0, 1);
        idle();

        applyStimulus(0, 12'h0, 32'h0, 0, 1, 12'h7C3, 32'h0000_DEAD, 1);
        idle();
        checkOutput("write out_data1", out_data[63:32], 32'h0000_DEAD);
        checkOutput("write outq_val1", 32'(outq_val[1]), 32'h1);
        checkOutput("write outq_data1", outq_data[63:32], 32'h0000_DEAD);
        checkOutput("write out_data0", out_data[31:0], 32'h0);
        checkOutput("write out_data2", out_data[95:64], 32'h0);
        checkOutput("write outq_val02", 32'({outq_val[2], outq_val[0]}), 32'h0);
        outq_rdy[1] = 1'b1;
        tick();
        tick();

        // Back-pressure: fill FIFO 0, then release the consumer during the refused write
        for (int v = 1; v <= 4; v++) begin
            applyStimulus(0, 12'h0, 32'h0, 0, 1, 12'h7C2, 32'(v), 1);
        end
        outq_rdy[0] = 1'b1;
        applyStimulus(1, 12'hFC1, 32'h0000_0101, 0, 1, 12'h7C2, 32'd5, 0);
        applyStimulus(0, 12'h0, 32'h0, 0, 1, 12'h7C2, 32'd5, 1);
        idle();
        for (int k = 0; k < 20 && streamQ[0].size() != 0; k++) tick();
        tick();
        checkOutput("drain stream0", 32'(streamQ[0].size()), 32'h0);
        checkOutput("drain outq_val", 32'(outq_val), 32'h0);
        checkOutput("drain out_data0", out_data[31:0], 32'd5);

        applyStimulus(1, 12'h123, 32'h0, 1, 1, 12'h456, 32'h0000_BEEF, 1);
        applyStimulus(0, 12'h0, 32'h0, 1, 1, 12'h7C5, 32'h0000_CAFE, 1);
        idle();
        tick();
        checkOutput("illegal out_data0", out_data[31:0], 32'd5);
        checkOutput("illegal out_data1", out_data[63:32], 32'h0000_DEAD);
        checkOutput("illegal out_data2", out_data[95:64], 32'h0);
        checkOutput("illegal outq_val", 32'(outq_val), 32'h0);

        // Asynchronous reset with three words queued
        outq_rdy = 3'b000;
        applyStimulus(0, 12'h0, 32'h0, 0, 1, 12'h7C2, 32'h11, 1);
        applyStimulus(0, 12'h0, 32'h0, 0, 1, 12'h7C3, 32'h22, 1);
        applyStimulus(0, 12'h0, 32'h0, 0, 1, 12'h7C4, 32'h33, 1);
        idle();
        checkOutput("pre-reset outq_val", 32'(outq_val), 32'h7);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async out_data0", out_data[31:0], 32'h0);
        checkOutput("async out_data1", out_data[63:32], 32'h0);
        checkOutput("async out_data2", out_data[95:64], 32'h0);
        checkOutput("async outq_val", 32'(outq_val), 32'h0);
        for (int j = 0; j < 3; j++) streamQ[j].delete();
        tick();
        rst = 1'b1;
        applyStimulus(1, 12'hFC0, 32'h0, 0, 0, 12'h0, 32'h0, 1);
        applyStimulus(1, 12'hFC1, 32'h0, 0, 0, 12'h0, 32'h0, 1);
        idle();
        tick();
        checkOutput("post-reset outq_val", 32'(outq_val), 32'h0);
        checkOutput("cycQ empty", 32'(cycQ.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
